// File: rtl/keystream_lfsr_gen.sv
// Galois-LFSR keystream generator with a serial seed/tap config chain.
// A burst shorter than 2M bits is flagged and leaves the running state untouched.
module keystream_lfsr_gen #(
  parameter int unsigned    M            = 32,
  parameter logic [M-1:0]   DEFAULT_SEED = M'(32'h0000_0001),
  parameter logic [M-1:0]   DEFAULT_TAPS = M'(32'h8020_0003)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cfg_en,
  input  logic cfg_i,
  output logic cfg_o,
  input  logic ks_en,
  output logic ks_bit,
  output logic ks_valid,
  output logic lockup,
  output logic cfg_err
);

  localparam int unsigned N  = 2 * M;
  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_CONFIG = 2'd1,
    ST_COMMIT = 2'd2,
    ST_LOCKUP = 2'd3
  } state_e;

  state_e          state_q;
  logic [M-1:0]    lfsr_q;
  logic [M-1:0]    taps_q;
  logic [N-1:0]    sh_q;
  logic [CW-1:0]   cnt_q;
  logic            cfg_err_q;

  logic [M-1:0]    lfsr_d;
  logic [N-1:0]    sh_d;
  logic [CW-1:0]   cnt_d;
  logic [M-1:0]    seed_sh;
  logic [M-1:0]    taps_sh;

  always_comb begin
    lfsr_d  = (lfsr_q >> 1) ^ (lfsr_q[0] ? taps_q : '0);
    sh_d    = {sh_q[N-2:0], cfg_i};
    cnt_d   = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CW'(1);
    seed_sh = sh_q[M-1:0];
    taps_sh = sh_q[N-1:M];
  end

  // Config shifting pre-empts every state, including a same-cycle advance in RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      lfsr_q    <= DEFAULT_SEED;
      taps_q    <= DEFAULT_TAPS;
      sh_q      <= '0;
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
    end else if (cfg_en) begin
      state_q <= ST_CONFIG;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (ks_en) lfsr_q <= lfsr_d;
        end
        ST_CONFIG: begin
          state_q <= ST_COMMIT;
        end
        ST_COMMIT: begin
          cnt_q <= '0;
          if (cnt_q < CNT_FULL) begin
            cfg_err_q <= 1'b1;
            state_q   <= (lfsr_q != '0 && taps_q != '0) ? ST_RUN : ST_LOCKUP;
          end else begin
            cfg_err_q <= 1'b0;
            lfsr_q    <= seed_sh;
            taps_q    <= taps_sh;
            state_q   <= (seed_sh == '0 || taps_sh == '0) ? ST_LOCKUP : ST_RUN;
          end
        end
        ST_LOCKUP: begin
          state_q <= ST_LOCKUP;
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign cfg_o    = sh_q[N-1];
  assign ks_bit   = lfsr_q[0];
  assign ks_valid = (state_q == ST_RUN);
  assign lockup   = (state_q == ST_LOCKUP);
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_keystream_lfsr_gen.sv
// Directed bench for keystream_lfsr_gen: default sequence, full/short/zero loads,
// contention between config and advance, and reset during a config burst.
module tb_keystream_lfsr_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic cfg_en;
  logic cfg_i;
  logic cfg_o;
  logic ks_en;
  logic ks_bit;
  logic ks_valid;
  logic lockup;
  logic cfg_err;

  int errors = 0;
  int checks = 0;

  keystream_lfsr_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_en   (cfg_en),
    .cfg_i    (cfg_i),
    .cfg_o    (cfg_o),
    .ks_en    (ks_en),
    .ks_bit   (ks_bit),
    .ks_valid (ks_valid),
    .lockup   (lockup),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are observed there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cfg_en = 1'b0; cfg_i = 1'b0; ks_en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Shift the top n bits of w, MSB first, then release cfg_en.
  task automatic shift_bits(input logic [63:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      cfg_en = 1'b1;
      cfg_i  = w[63-i];
      tick();
    end
    cfg_en = 1'b0;
    cfg_i  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (cfg_o !== 1'b0)   begin errors++; $display("FAIL reset_cfg_o got=%b exp=0", cfg_o); end
    checks++; if (ks_bit !== 1'b1)  begin errors++; $display("FAIL reset_ks_bit got=%b exp=1", ks_bit); end
    checks++; if (ks_valid !== 1'b1) begin errors++; $display("FAIL reset_ks_valid got=%b exp=1", ks_valid); end
    checks++; if (lockup !== 1'b0)  begin errors++; $display("FAIL reset_lockup got=%b exp=0", lockup); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
    checks++; if (dut.lfsr_q !== 32'h0000_0001) begin errors++; $display("FAIL reset_lfsr got=%h exp=00000001", dut.lfsr_q); end
    checks++; if (dut.taps_q !== 32'h8020_0003) begin errors++; $display("FAIL reset_taps got=%h exp=80200003", dut.taps_q); end
  endtask

  task automatic test_default_seq();
    logic [31:0] exp_lfsr [5];
    logic        exp_bit  [5];
    exp_lfsr = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001, 32'hB02C_0003};
    exp_bit  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      ks_en = 1'b1;
      checks++; if (ks_bit !== exp_bit[i]) begin errors++; $display("FAIL default_ks_bit[%0d] got=%b exp=%b", i, ks_bit, exp_bit[i]); end
      checks++; if (dut.lfsr_q !== exp_lfsr[i]) begin errors++; $display("FAIL default_lfsr[%0d] got=%h exp=%h", i, dut.lfsr_q, exp_lfsr[i]); end
      checks++; if (ks_valid !== 1'b1) begin errors++; $display("FAIL default_ks_valid[%0d] got=%b exp=1", i, ks_valid); end
      tick();
    end
    ks_en = 1'b0;
    checks++; if (dut.lfsr_q !== 32'hD836_0002) begin errors++; $display("FAIL default_lfsr_after got=%h exp=d8360002", dut.lfsr_q); end
    tick();
    tick();
    checks++; if (dut.lfsr_q !== 32'hD836_0002) begin errors++; $display("FAIL default_hold got=%h exp=d8360002", dut.lfsr_q); end
  endtask

  task automatic test_full_config();
    logic [63:0] w;
    w = {32'h8020_0003, 32'hA5A5_A5A5};
    for (int i = 0; i < 64; i++) begin
      cfg_en = 1'b1;
      cfg_i  = w[63-i];
      tick();
      checks++; if (ks_valid !== 1'b0) begin errors++; $display("FAIL full_shift_ks_valid[%0d] got=%b exp=0", i, ks_valid); end
      if (i == 62) begin
        checks++; if (cfg_o !== 1'b0) begin errors++; $display("FAIL full_cfg_o_63 got=%b exp=0", cfg_o); end
      end
      if (i == 63) begin
        checks++; if (cfg_o !== 1'b1) begin errors++; $display("FAIL full_cfg_o_64 got=%b exp=1", cfg_o); end
      end
    end
    cfg_en = 1'b0;
    cfg_i  = 1'b0;
    tick();
    checks++; if (ks_valid !== 1'b0) begin errors++; $display("FAIL full_commit_ks_valid got=%b exp=0", ks_valid); end
    tick();
    checks++; if (ks_valid !== 1'b1) begin errors++; $display("FAIL full_run_ks_valid got=%b exp=1", ks_valid); end
    checks++; if (ks_bit !== 1'b1)   begin errors++; $display("FAIL full_ks_bit got=%b exp=1", ks_bit); end
    checks++; if (cfg_err !== 1'b0)  begin errors++; $display("FAIL full_cfg_err got=%b exp=0", cfg_err); end
    checks++; if (lockup !== 1'b0)   begin errors++; $display("FAIL full_lockup got=%b exp=0", lockup); end
    checks++; if (dut.lfsr_q !== 32'hA5A5_A5A5) begin errors++; $display("FAIL full_lfsr got=%h exp=a5a5a5a5", dut.lfsr_q); end
    ks_en = 1'b1;
    tick();
    ks_en = 1'b0;
    checks++; if (dut.lfsr_q !== 32'hD2F2_D2D1) begin errors++; $display("FAIL full_advance got=%h exp=d2f2d2d1", dut.lfsr_q); end
  endtask

  task automatic test_short_config();
    do_reset();
    ks_en = 1'b1;
    tick(); tick(); tick();
    ks_en = 1'b0;
    shift_bits(64'hFFFF_FFFF_FFFF_FFFF, 40);
    tick();
    checks++; if (ks_valid !== 1'b0) begin errors++; $display("FAIL short_commit_ks_valid got=%b exp=0", ks_valid); end
    tick();
    checks++; if (cfg_err !== 1'b1)  begin errors++; $display("FAIL short_cfg_err got=%b exp=1", cfg_err); end
    checks++; if (ks_valid !== 1'b1) begin errors++; $display("FAIL short_ks_valid got=%b exp=1", ks_valid); end
    checks++; if (dut.lfsr_q !== 32'h6018_0001) begin errors++; $display("FAIL short_lfsr got=%h exp=60180001", dut.lfsr_q); end
    ks_en = 1'b1;
    checks++; if (ks_bit !== 1'b1) begin errors++; $display("FAIL short_bit0 got=%b exp=1", ks_bit); end
    tick();
    checks++; if (ks_bit !== 1'b1) begin errors++; $display("FAIL short_bit1 got=%b exp=1", ks_bit); end
    tick();
    ks_en = 1'b0;
    checks++; if (dut.lfsr_q !== 32'hD836_0002) begin errors++; $display("FAIL short_lfsr_after got=%h exp=d8360002", dut.lfsr_q); end
  endtask

  task automatic test_contention_reset();
    cfg_en = 1'b1;
    cfg_i  = 1'b1;
    ks_en  = 1'b1;
    tick();
    ks_en  = 1'b0;
    checks++; if (dut.lfsr_q !== 32'hD836_0002) begin errors++; $display("FAIL contend_lfsr got=%h exp=d8360002", dut.lfsr_q); end
    checks++; if (ks_valid !== 1'b0) begin errors++; $display("FAIL contend_ks_valid got=%b exp=0", ks_valid); end
    shift_bits(64'h5555_5555_5555_5555, 19);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (dut.lfsr_q !== 32'h0000_0001) begin errors++; $display("FAIL midreset_lfsr got=%h exp=00000001", dut.lfsr_q); end
    checks++; if (dut.taps_q !== 32'h8020_0003) begin errors++; $display("FAIL midreset_taps got=%h exp=80200003", dut.taps_q); end
    checks++; if (cfg_err !== 1'b0)  begin errors++; $display("FAIL midreset_cfg_err got=%b exp=0", cfg_err); end
    checks++; if (ks_valid !== 1'b1) begin errors++; $display("FAIL midreset_ks_valid got=%b exp=1", ks_valid); end
    checks++; if (cfg_o !== 1'b0)    begin errors++; $display("FAIL midreset_cfg_o got=%b exp=0", cfg_o); end
    tick();
    tick();
    checks++; if (ks_valid !== 1'b1) begin errors++; $display("FAIL midreset_no_commit_valid got=%b exp=1", ks_valid); end
    checks++; if (dut.lfsr_q !== 32'h0000_0001) begin errors++; $display("FAIL midreset_no_commit_lfsr got=%h exp=00000001", dut.lfsr_q); end
    checks++; if (cfg_err !== 1'b0)  begin errors++; $display("FAIL midreset_no_commit_err got=%b exp=0", cfg_err); end
  endtask

  task automatic test_zero_config();
    shift_bits({32'h8020_0003, 32'h0000_0000}, 64);
    tick(); tick();
    checks++; if (lockup !== 1'b1)   begin errors++; $display("FAIL zseed_lockup got=%b exp=1", lockup); end
    checks++; if (ks_valid !== 1'b0) begin errors++; $display("FAIL zseed_ks_valid got=%b exp=0", ks_valid); end
    checks++; if (cfg_err !== 1'b0)  begin errors++; $display("FAIL zseed_cfg_err got=%b exp=0", cfg_err); end
    ks_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ks_bit !== 1'b0) begin errors++; $display("FAIL zseed_ks_bit[%0d] got=%b exp=0", i, ks_bit); end
    end
    ks_en = 1'b0;
    checks++; if (lockup !== 1'b1) begin errors++; $display("FAIL zseed_stays got=%b exp=1", lockup); end
    shift_bits({32'h0000_0000, 32'h0000_0005}, 64);
    tick(); tick();
    checks++; if (lockup !== 1'b1) begin errors++; $display("FAIL ztaps_lockup got=%b exp=1", lockup); end
    shift_bits({32'h8020_0003, 32'h0000_0001}, 64);
    tick(); tick();
    checks++; if (lockup !== 1'b0)   begin errors++; $display("FAIL recover_lockup got=%b exp=0", lockup); end
    checks++; if (ks_valid !== 1'b1) begin errors++; $display("FAIL recover_ks_valid got=%b exp=1", ks_valid); end
    checks++; if (ks_bit !== 1'b1)   begin errors++; $display("FAIL recover_ks_bit got=%b exp=1", ks_bit); end
    ks_en = 1'b1;
    tick();
    ks_en = 1'b0;
    checks++; if (dut.lfsr_q !== 32'h8020_0003) begin errors++; $display("FAIL recover_advance got=%h exp=80200003", dut.lfsr_q); end
  endtask

  initial begin
    rst_n = 1'b0; cfg_en = 1'b0; cfg_i = 1'b0; ks_en = 1'b0;
    test_reset();
    test_default_seq();
    test_full_config();
    test_short_config();
    test_contention_reset();
    test_zero_config();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keystream_lfsr_gen.md
Name: keystream_lfsr_gen

Overview:
- Serially configurable Galois-LFSR keystream generator.
- Sits directly upstream of the dual XOR stream cipher stage and supplies it one keystream bit per advance request.
- Seed and tap polynomial are loaded over the same 1-bit cfg_en/cfg_i/cfg_o daisy-chain used by the cipher, so the two blocks chain on one config bus.
- Detects bad configurations: short load, all-zero seed, all-zero taps.

Parameters:
- M, 32, LFSR width in bits (≥ 8).
- DEFAULT_SEED, 32'h0000_0001, LFSR state loaded at reset (M bits).
- DEFAULT_TAPS, 32'h8020_0003, Galois tap mask at reset (x^32+x^22+x^2+x+1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- cfg_en  in  1  config shift enable.
- cfg_i  in  1  config serial data in.
- cfg_o  out  1  config serial data out (chain MSB), for daisy-chaining.
- ks_en  in  1  advance request from downstream cipher.
- ks_bit  out  1  current keystream bit (lfsr[0]).
- ks_valid  out  1  keystream usable (FSM in RUN).
- lockup  out  1  committed seed or taps is zero.
- cfg_err  out  1  sticky: last config burst shorter than 2M bits.

Behaviour:
- Reset values (rst_n low at a clk edge, synchronous):
  - lfsr=DEFAULT_SEED, taps=DEFAULT_TAPS.
  - Shift chain and bit counter = 0.
  - FSM=RUN.
  - Outputs: cfg_o=0, ks_bit=DEFAULT_SEED[0], ks_valid=1, lockup=0, cfg_err=0.
- Reset mid-config discards the chain; no commit occurs.
- Registers:
  - lfsr[M-1:0] and taps[M-1:0].
  - Chain sh[2M-1:0] = {taps_sh, seed_sh}.
  - cnt: saturating counter, 0..2M.
- FSM states: RUN, CONFIG, COMMIT, LOCKUP. ks_valid=(state==RUN); lockup=(state==LOCKUP).
- Any state, cfg_en=1:
  - Next state is CONFIG.
  - sh <= {sh[2M-2:0], cfg_i}; cnt <= min(cnt+1, 2M).
  - cfg_o = sh[2M-1] (register output), so a bit re-emerges on cfg_o after 2M shifts.
- CONFIG, cfg_en=0 -> COMMIT. No shift on that cycle.
- COMMIT (exactly one cycle, ks_valid=0), then cnt <= 0:
  - If cnt<2M: cfg_err<=1, lfsr/taps unchanged, and next state = RUN if (lfsr!=0 && taps!=0), else LOCKUP.
  - Else: cfg_err<=0, lfsr<=seed_sh, taps<=taps_sh, and next state = LOCKUP if seed_sh==0 or taps_sh==0, else RUN.
  - Over-length bursts are legal: the last 2M bits shifted win.
- RUN, ks_en=1: lfsr <= (lfsr>>1) ^ (lfsr[0] ? taps : 0).
  - Consumer samples ks_bit in the same cycle it asserts ks_en.
  - The new bit appears the next cycle, so one bit is delivered per ks_en cycle at zero latency.
- ks_en outside RUN is ignored; lfsr holds.
- lfsr also holds whenever ks_en=0.
- LOCKUP exits only via cfg_en=1 (-> CONFIG) or reset.
- Simultaneous cfg_en=1 and ks_en=1 in RUN: cfg_en wins; there is no advance on that cycle.
- Width rules:
  - All XOR/shift operations are M bits.
  - cnt is $clog2(2M+1) bits and never wraps.
- No combinational path from inputs to outputs. ks_bit, ks_valid and lockup are decoded from registers only.

Test Plan:
- Default sequence: release reset, ks_en=1 for 5 cycles.
  - Required: ks_bit = 1,1,0,1,1.
  - Required: lfsr = 0x1 -> 0x80200003 -> 0xC0300002 -> 0x60180001 -> 0xB02C0003.
  - Required: ks_valid=1 throughout.
- Full config: cfg_en=1 for 64 cycles shifting taps=0x80200003 (MSB first) then seed=0xA5A5A5A5 (MSB first), then cfg_en=0.
  - Required: ks_valid=0 for the 64 shift cycles and the 1 COMMIT cycle.
  - Required: then RUN with ks_bit=1, cfg_err=0.
  - Required: the first config bit appears on cfg_o after the 64th shift.
- Short config: advance default LFSR 3 steps, then shift 40 bits.
  - Required: cfg_err=1, back in RUN.
  - Required: the next ks_bit sequence continues from 0x60180001 (1,1,...) unchanged.
- Zero seed: full 64-bit load with taps=0x80200003, seed=0.
  - Required: lockup=1, ks_valid=0.
  - Required: ks_en pulses leave ks_bit=0.
  - Required: a subsequent valid load returns to RUN with lockup=0.
- Contention and reset mid-op: assert cfg_en and ks_en together in RUN, then drop rst_n during CONFIG after 20 bits.
  - Required: no LFSR advance on the contention cycle.
  - Required: reset restores lfsr=0x1, taps=0x80200003, cfg_err=0, FSM=RUN with no commit.
